// File: rtl/hazard_unit.sv
// Execute-stage hazard controller: operand forwarding, load-use stall, PC-write
// and branch flush control, with saturating stall/flush performance counters.
module hazard_unit #(
  parameter int ADDR   = 4,
  parameter int PC_REG = 15,
  parameter int CNT    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR-1:0]   RA1D,
  input  logic [ADDR-1:0]   RA2D,
  input  logic [ADDR-1:0]   RA1E,
  input  logic [ADDR-1:0]   RA2E,
  input  logic [ADDR-1:0]   WA3E,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              BranchTakenE,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT-1:0]    StallCount,
  output logic [CNT-1:0]    FlushCount,
  // {WA3M, RegWriteM, MemtoRegM, PCSrcM, WA3W, RegWriteW, PCSrcW}
  output logic [2*ADDR+4:0] dbg_shadow
);

  localparam logic [ADDR-1:0] PC_IDX  = ADDR'(PC_REG);
  localparam logic [CNT-1:0]  CNT_MAX = {CNT{1'b1}};

  logic [ADDR-1:0] wa3m, wa3w;
  logic            regwritem, memtoregm, pcsrcm;
  logic            regwritew, pcsrcw;
  logic            ldr_stall, pc_wr_pending;

  // Shadow M/W stages never stall; a flushed E slot is already zeroed upstream.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      wa3m      <= '0;
      regwritem <= 1'b0;
      memtoregm <= 1'b0;
      pcsrcm    <= 1'b0;
      wa3w      <= '0;
      regwritew <= 1'b0;
      pcsrcw    <= 1'b0;
    end else begin
      wa3m      <= WA3E;
      regwritem <= RegWriteE;
      memtoregm <= MemtoRegE;
      pcsrcm    <= PCSrcE;
      wa3w      <= wa3m;
      regwritew <= regwritem;
      pcsrcw    <= pcsrcm;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [ADDR-1:0] ra,
    input logic [ADDR-1:0] wm,
    input logic            rwm,
    input logic [ADDR-1:0] ww,
    input logic            rww
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_IDX) begin
      if (rwm && (wm == ra))      sel = 2'b10;
      else if (rww && (ww == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RA1E, wa3m, regwritem, wa3w, regwritew);
  assign ForwardBE = fwd_sel(RA2E, wa3m, regwritem, wa3w, regwritew);

  assign ldr_stall     = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pc_wr_pending = PCSrcD || PCSrcE || pcsrcm;

  // Load-use and taken branch may coincide; downstream registers give flush priority.
  assign StallF = ldr_stall || pc_wr_pending;
  assign StallD = ldr_stall;
  assign FlushD = pc_wr_pending || pcsrcw || BranchTakenE;
  assign FlushE = ldr_stall || BranchTakenE;

  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != CNT_MAX))
        StallCount <= StallCount + 1'b1;
      if ((FlushD || FlushE) && (FlushCount != CNT_MAX))
        FlushCount <= FlushCount + 1'b1;
    end
  end

  assign dbg_shadow = {wa3m, regwritem, memtoregm, pcsrcm, wa3w, regwritew, pcsrcw};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: table-driven forwarding vectors, hand-written multi-cycle
// stall/flush/counter sequences, and randomized forwarding against a reference model.
module tb_hazard_unit;

  localparam int ADDR = 4;
  localparam int CNT  = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [ADDR-1:0] RA1D, RA2D, RA1E, RA2E, WA3E;
  logic            RegWriteE, MemtoRegE, PCSrcD, PCSrcE, BranchTakenE, CntClr;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, FlushD, FlushE;
  logic [CNT-1:0]  StallCount, FlushCount;
  logic [2*ADDR+4:0] dbg_shadow;

  logic [7:0] ctl_act;
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] wa3w;
    logic       rww;
    logic [3:0] wa3m;
    logic       rwm;
    logic [3:0] ra1e;
    logic [3:0] ra2e;
    logic [1:0] fa;
    logic [1:0] fb;
  } fwd_vec_t;

  fwd_vec_t vecs[7];

  hazard_unit #(.ADDR(ADDR), .PC_REG(15), .CNT(CNT)) dut (
    .CLK(CLK), .RESET(RESET),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .BranchTakenE(BranchTakenE), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount), .dbg_shadow(dbg_shadow)
  );

  assign ctl_act = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};

  // Clock: state updates on negedge, outputs sampled at posedge.
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0; WA3E = '0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; PCSrcD = 1'b0; PCSrcE = 1'b0;
    BranchTakenE = 1'b0; CntClr = 1'b0;
  endtask

  task automatic expect_ctl(input logic [7:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check_ctl(input string name, input bit at_edge);
    logic [7:0] e;
    if (at_edge) @(posedge CLK);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued, got %b", name, ctl_act);
    end else begin
      e = exp_q.pop_front();
      if (ctl_act !== e) begin
        errors++;
        $display("FAIL %s: got fa/fb/sf/sd/fd/fe=%b need %b", name, ctl_act, e);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic clear_counters();
    idle();
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
  endtask

  // First E instruction ends in W, second in M.
  task automatic load_shadow(input logic [3:0] ww, input logic rww,
                             input logic [3:0] wm, input logic rwm);
    WA3E = ww; RegWriteE = rww;
    tick();
    WA3E = wm; RegWriteE = rwm;
    tick();
    WA3E = '0; RegWriteE = 1'b0;
  endtask

  function automatic logic [1:0] fwd_model(input logic [3:0] ra, input logic [3:0] wm,
                                           input logic rwm, input logic [3:0] ww,
                                           input logic rww);
    if (ra == 4'd15) return 2'b00;
    if (rwm && wm == ra) return 2'b10;
    if (rww && ww == ra) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    logic [3:0] ww, wm, ra1, ra2;
    logic       rww, rwm;

    vecs[0] = '{4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 4'd3, 2'b10, 2'b10};
    vecs[1] = '{4'd3, 1'b1, 4'd5, 1'b1, 4'd3, 4'd5, 2'b01, 2'b10};
    vecs[2] = '{4'd15, 1'b1, 4'd15, 1'b1, 4'd15, 4'd15, 2'b00, 2'b00};
    vecs[3] = '{4'd7, 1'b0, 4'd7, 1'b0, 4'd7, 4'd7, 2'b00, 2'b00};
    vecs[4] = '{4'd4, 1'b1, 4'd9, 1'b0, 4'd4, 4'd9, 2'b01, 2'b00};
    vecs[5] = '{4'd2, 1'b0, 4'd2, 1'b1, 4'd1, 4'd2, 2'b00, 2'b10};
    vecs[6] = '{4'd0, 1'b1, 4'd1, 1'b1, 4'd0, 4'd1, 2'b01, 2'b10};

    // Reset state
    idle();
    #1 RESET = 1'b0;
    #2;
    expect_ctl(8'b0000_0000);
    check_ctl("reset_ctl", 1'b0);
    check_val("reset_stall_cnt", 16'(StallCount), 16'd0);
    check_val("reset_flush_cnt", 16'(FlushCount), 16'd0);
    @(negedge CLK);
    #1 RESET = 1'b1;

    // Forwarding table
    for (int i = 0; i < 7; i++) begin
      load_shadow(vecs[i].wa3w, vecs[i].rww, vecs[i].wa3m, vecs[i].rwm);
      RA1E = vecs[i].ra1e;
      RA2E = vecs[i].ra2e;
      expect_ctl({vecs[i].fa, vecs[i].fb, 4'b0000});
      check_ctl($sformatf("fwd_vec%0d", i), 1'b1);
    end

    // Producer visibility: M after one negedge, W after two, gone after three
    idle();
    WA3E = 4'd6; RegWriteE = 1'b1;
    tick();
    idle(); RA1E = 4'd6;
    expect_ctl(8'b1000_0000); check_ctl("age_m", 1'b1);
    tick();
    expect_ctl(8'b0100_0000); check_ctl("age_w", 1'b1);
    tick();
    expect_ctl(8'b0000_0000); check_ctl("age_gone", 1'b1);

    // Load-use: one stall cycle, then W forward two negedges later
    clear_counters();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2;
    expect_ctl(8'b0000_1101); check_ctl("ldr_stall", 1'b1);
    tick();
    idle();
    check_val("ldr_stall_cnt", 16'(StallCount), 16'd1);
    check_val("ldr_flush_cnt", 16'(FlushCount), 16'd1);
    check_val("ldr_shadow_m", 16'(dbg_shadow[12:7]), 16'({4'd2, 1'b1, 1'b1}));
    expect_ctl(8'b0000_0000); check_ctl("ldr_bubble", 1'b1);
    tick();
    RA2E = 4'd2;
    expect_ctl(8'b0001_0000); check_ctl("ldr_fwd_w", 1'b1);

    // PC write: StallF for D,E,M; FlushD through W
    clear_counters();
    PCSrcD = 1'b1;
    expect_ctl(8'b0000_1010); check_ctl("pc_d", 1'b1);
    tick();
    PCSrcD = 1'b0; PCSrcE = 1'b1;
    expect_ctl(8'b0000_1010); check_ctl("pc_e", 1'b1);
    tick();
    PCSrcE = 1'b0;
    expect_ctl(8'b0000_1010); check_ctl("pc_m", 1'b1);
    tick();
    expect_ctl(8'b0000_0010); check_ctl("pc_w", 1'b1);
    tick();
    expect_ctl(8'b0000_0000); check_ctl("pc_done", 1'b1);
    check_val("pc_flush_cnt", 16'(FlushCount), 16'd4);
    check_val("pc_stall_cnt", 16'(StallCount), 16'd0);

    // Load-use coincident with taken branch
    clear_counters();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd4; RA1D = 4'd4; BranchTakenE = 1'b1;
    expect_ctl(8'b0000_1111); check_ctl("ldr_branch", 1'b1);
    tick();
    idle();
    check_val("ldr_branch_stall_cnt", 16'(StallCount), 16'd1);
    check_val("ldr_branch_flush_cnt", 16'(FlushCount), 16'd1);

    // Saturation and clear
    clear_counters();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    repeat (20) tick();
    check_val("sat_stall_cnt", 16'(StallCount), 16'd15);
    check_val("sat_flush_cnt", 16'(FlushCount), 16'd15);
    CntClr = 1'b1;
    tick();
    check_val("clr_stall_cnt", 16'(StallCount), 16'd0);
    check_val("clr_flush_cnt", 16'(FlushCount), 16'd0);
    CntClr = 1'b0;
    tick();
    check_val("post_clr_stall_cnt", 16'(StallCount), 16'd1);

    // Asynchronous reset mid-run with counters at 5, RegWriteM=1, PCSrcM=1
    clear_counters();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd3; RA1D = 4'd3;
    repeat (4) tick();
    PCSrcE = 1'b1;
    tick();
    idle(); RA1E = 4'd3;
    expect_ctl(8'b1000_1010); check_ctl("pre_reset", 1'b1);
    check_val("pre_reset_stall_cnt", 16'(StallCount), 16'd5);
    check_val("pre_reset_flush_cnt", 16'(FlushCount), 16'd5);
    #1 RESET = 1'b0;
    #1;
    expect_ctl(8'b0000_0000); check_ctl("async_reset", 1'b0);
    check_val("async_reset_stall_cnt", 16'(StallCount), 16'd0);
    check_val("async_reset_flush_cnt", 16'(FlushCount), 16'd0);
    @(negedge CLK);
    #1 RESET = 1'b1;
    expect_ctl(8'b0000_0000); check_ctl("post_reset", 1'b1);

    // Randomized forwarding against the reference model
    for (int i = 0; i < 16; i++) begin
      ww  = 4'($urandom_range(0, 15));
      wm  = 4'($urandom_range(0, 15));
      rww = 1'($urandom_range(0, 1));
      rwm = 1'($urandom_range(0, 1));
      load_shadow(ww, rww, wm, rwm);
      ra1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : wm;
      ra2 = ($urandom_range(0, 1) == 0) ? ww : 4'($urandom_range(0, 15));
      RA1E = ra1;
      RA2E = ra2;
      expect_ctl({fwd_model(ra1, wm, rwm, ww, rww), fwd_model(ra2, wm, rwm, ww, rww), 4'b0000});
      check_ctl($sformatf("rand_fwd%0d", i), 1'b1);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d entries never compared, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
